// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM next-word predictor control path.
package lstm_pkg;

  localparam int NUM_PARAMS    = 6002;
  localparam int BW            = 32;
  localparam int SEQ_LENGTH    = 4;
  localparam int ENC           = 27;
  localparam int AW            = $clog2(NUM_PARAMS);
  localparam int SETTLE_CYCLES = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_COMPUTE,
    S_OUT
  } seq_state_t;

endpackage

// File: rtl/lstm_param_writer.sv
// Parameter-image write port: address counter plus registered memory write.
module lstm_param_writer #(
  parameter int NUM_PARAMS = 6002,
  parameter int BW         = 32,
  parameter int AW         = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr,
  input  logic [BW-1:0] wr_data,
  output logic          last,
  output logic          mem_ena,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addr,
  output logic [BW-1:0] mem_dina
);

  logic [AW-1:0] cnt;

  // The write in flight targets the final image slot.
  assign last = (cnt == AW'(NUM_PARAMS - 1));

  // One registered write per accepted word; the counter then advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mem_ena  <= 1'b0;
      mem_wea  <= 1'b0;
      mem_addr <= '0;
      mem_dina <= '0;
    end else if (clear) begin
      cnt     <= '0;
      mem_ena <= 1'b0;
      mem_wea <= 1'b0;
    end else if (wr) begin
      mem_ena  <= 1'b1;
      mem_wea  <= 1'b1;
      mem_addr <= cnt;
      mem_dina <= wr_data;
      cnt      <= cnt + 1'b1;
    end else begin
      mem_ena <= 1'b0;
      mem_wea <= 1'b0;
    end
  end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Sequencing controller: parameter load, word presentation, prediction capture.
module lstm_seq_ctrl #(
  parameter int NUM_PARAMS    = lstm_pkg::NUM_PARAMS,
  parameter int BW            = lstm_pkg::BW,
  parameter int SEQ_LENGTH    = lstm_pkg::SEQ_LENGTH,
  parameter int ENC           = lstm_pkg::ENC,
  parameter int SETTLE_CYCLES = lstm_pkg::SETTLE_CYCLES,
  parameter int AW            = lstm_pkg::AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic                      param_valid,
  output logic                      param_ready,
  input  logic [BW-1:0]             param_data,
  output logic                      mem_ena,
  output logic                      mem_wea,
  output logic [AW-1:0]             mem_addr,
  output logic [BW-1:0]             mem_dina,
  input  logic                      word_valid,
  output logic                      word_ready,
  input  logic [ENC*SEQ_LENGTH-1:0] word_in,
  output logic [ENC*SEQ_LENGTH-1:0] core_word,
  input  logic [5:0]                core_char,
  output logic                      pred_valid,
  input  logic                      pred_ready,
  output logic [5:0]                pred_char,
  output logic                      pred_err,
  output logic                      loaded
);

  import lstm_pkg::*;

  localparam int         SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [5:0] ENC_LIM = 6'(ENC);

  seq_state_t    state;
  logic [SW-1:0] settle;
  logic          param_hs;
  logic          load_clear;
  logic          load_last;

  assign param_hs   = param_valid & param_ready;
  // A reload may begin from IDLE or READY only; it wins over a word in READY.
  assign load_clear = load_start & ((state == S_IDLE) | (state == S_READY));

  lstm_param_writer #(
    .NUM_PARAMS (NUM_PARAMS),
    .BW         (BW),
    .AW         (AW)
  ) u_writer (
    .clk      (clk),
    .rst      (rst),
    .clear    (load_clear),
    .wr       (param_hs),
    .wr_data  (param_data),
    .last     (load_last),
    .mem_ena  (mem_ena),
    .mem_wea  (mem_wea),
    .mem_addr (mem_addr),
    .mem_dina (mem_dina)
  );

  // Sequencing FSM with all handshake and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      param_ready <= 1'b0;
      word_ready  <= 1'b0;
      pred_valid  <= 1'b0;
      pred_err    <= 1'b0;
      pred_char   <= '0;
      core_word   <= '0;
      loaded      <= 1'b0;
      settle      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state       <= S_LOAD;
            param_ready <= 1'b1;
            loaded      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (param_hs && load_last) begin
            state       <= S_READY;
            param_ready <= 1'b0;
            word_ready  <= 1'b1;
            loaded      <= 1'b1;
          end
        end
        S_READY: begin
          if (load_start) begin
            state       <= S_LOAD;
            word_ready  <= 1'b0;
            param_ready <= 1'b1;
            loaded      <= 1'b0;
          end else if (word_valid) begin
            state      <= S_COMPUTE;
            word_ready <= 1'b0;
            core_word  <= word_in;
            settle     <= SW'(SETTLE_CYCLES - 1);
          end
        end
        S_COMPUTE: begin
          if (settle == '0) begin
            state      <= S_OUT;
            pred_char  <= core_char;
            pred_err   <= (core_char >= ENC_LIM);
            pred_valid <= 1'b1;
          end else begin
            settle <= settle - 1'b1;
          end
        end
        S_OUT: begin
          if (pred_ready) begin
            state      <= S_READY;
            pred_valid <= 1'b0;
            word_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lstm_seq_ctrl.md
# lstm_seq_ctrl

Sequencing controller for the LSTM next-word predictor. It streams the flattened parameter image from a valid/ready source into the parameter memory through its `ena`/`wea`/`dina` write port. It then accepts one encoded input word at a time, holds it stable on the forward-pass word input for a fixed settle window, and captures the predicted character. The captured result is returned through a valid/ready output handshake. The block sits between the host/stream interface and `lstm_model`; it is the only agent that drives the model's parameter-write and word inputs.

## Interface
- `NUM_PARAMS`, 6002, number of 32-bit parameter words in one full image
- `BW`, 32, parameter word width
- `SEQ_LENGTH`, 4, characters per input word
- `ENC`, 27, one-hot encoding width per character
- `SETTLE_CYCLES`, 8, cycles the word is held before the prediction is sampled; must be ≥1
- `AW`, 13, parameter address width, equal to clog2(`NUM_PARAMS`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `load_start`  in  1  one-cycle pulse requesting a full parameter reload
- `param_valid`  in  1  parameter stream word valid
- `param_ready`  out  1  controller accepts a parameter word
- `param_data`  in  `BW`  parameter stream word
- `mem_ena`  out  1  parameter memory enable
- `mem_wea`  out  1  parameter memory write enable
- `mem_addr`  out  `AW`  parameter write address
- `mem_dina`  out  `BW`  parameter write data
- `word_valid`  in  1  input word valid
- `word_ready`  out  1  controller accepts a word
- `word_in`  in  `ENC*SEQ_LENGTH`  encoded input word
- `core_word`  out  `ENC*SEQ_LENGTH`  registered word driven to the forward pass
- `core_char`  in  6  predicted character index from the forward pass
- `pred_valid`  out  1  prediction available
- `pred_ready`  in  1  consumer accepts the prediction
- `pred_char`  out  6  captured prediction
- `pred_err`  out  1  captured `core_char` ≥ `ENC`; valid with `pred_valid`
- `loaded`  out  1  a complete parameter image has been written

## Operation
FSM states: IDLE, LOAD, READY, COMPUTE, OUT. All state and all outputs are registered.

**IDLE**
- All handshake outputs are 0.
- `load_start` → LOAD. The write counter clears to 0 and `loaded` clears.

**LOAD**
- `param_ready` = 1.
- Each `param_valid & param_ready` handshake registers one write: `mem_ena` = `mem_wea` = 1, `mem_addr` = counter, `mem_dina` = `param_data`. The counter then increments.
- Cycles without a handshake drive `mem_ena` = `mem_wea` = 0.
- The handshake at counter = `NUM_PARAMS`-1 moves the FSM to READY and sets `loaded` = 1.
- `load_start` is ignored while in LOAD.

**READY**
- `word_ready` = 1.
- Handshake: `core_word` ← `word_in`, settle counter ← `SETTLE_CYCLES`-1, go to COMPUTE.
- If `load_start` and `word_valid` are both high, `load_start` wins. The FSM goes to LOAD, no word is accepted, and `word_ready` drops from the next cycle.

**COMPUTE**
- `core_word` holds.
- The settle counter decrements once per cycle.
- At 0: `pred_char` ← `core_char`, `pred_err` ← (`core_char` ≥ `ENC`), `pred_valid` = 1, go to OUT.

**OUT**
- `pred_valid`, `pred_char` and `pred_err` hold until `pred_valid & pred_ready`.
- On that handshake: `pred_valid` = 0, go to READY.
- `core_word` keeps its last value.

**General**
- `load_start` is ignored in COMPUTE and OUT.
- `loaded` is cleared only by `rst` or by entry to LOAD.

## Timing
- Reset values: FSM = IDLE; `param_ready`, `word_ready`, `pred_valid`, `pred_err`, `loaded`, `mem_ena`, `mem_wea` = 0; `mem_addr`, `mem_dina`, `core_word`, `pred_char` = 0. Both counters = 0.
- `rst` mid-LOAD: the partially written image is abandoned and `loaded` = 0. The memory contents are not cleared.
- Memory write: appears on `mem_*` in the cycle after the parameter handshake, one cycle per word. Full load takes ≥ `NUM_PARAMS` cycles; back-to-back `param_valid` achieves exactly `NUM_PARAMS`.
- Word to prediction:
  - Word handshake at edge T.
  - `core_char` is sampled at edge T+`SETTLE_CYCLES`.
  - `pred_valid` is high from that edge onward.
- Throughput: one word per `SETTLE_CYCLES`+2 cycles when `pred_ready` is held high.
- `word_ready` and `pred_valid` are never high in the same cycle.

## Structure
- Shared package `lstm_pkg`:
  - FSM state enum
  - model dimensions `NUM_PARAMS`, `ENC`, `SEQ_LENGTH`, `BW`
  - `AW` derived from them
- One natural sub-module: `lstm_param_writer`, covering the LOAD counter, address generation and registered write port. The FSM, settle counter and output register stay in the top.

## Test plan
- **Reset then load:** `rst`, then `load_start` with `NUM_PARAMS`=6002 back-to-back words (data = index) → addresses 0..6001 written with data = address, one per cycle. `loaded`=1 in the cycle after the last write; `param_ready` then drops.
- **Gapped stream:** `param_valid` toggling 1/0 → no write on idle cycles, address sequence unbroken, 12004 cycles total.
- **Single inference:**
  - Word 0x…A5 accepted at T with `core_char` forced to 5 → `pred_valid` rises at T+8 with `pred_char`=5 and `pred_err`=0.
  - `pred_ready` delayed 3 cycles → outputs hold.
- **Error flag:** `core_char`=30 → `pred_err`=1, `pred_char`=30.
- **Collision:** `load_start` and `word_valid` together in READY → FSM enters LOAD, no prediction produced, `loaded`=0.
- **Reset mid-operation:** `rst` after 100 load writes → all outputs return to reset values. A subsequent `word_valid` is not accepted until a full reload completes.
